// File: rtl/irq_controller.sv
// irq_controller -- edge-triggered interrupt controller with fixed priority.
//
// Rising edges on irq_src lines are latched into a pending register.
// Pending bits that are enabled by the mask are arbitrated, lowest index
// first. The winner is handed to the processor through a
// request/acknowledge handshake: IDLE -> REQ -> WAIT_REL -> IDLE.
//
// Ports:
//   CLOCK_50    clock; all state changes on its rising edge
//   reset       asynchronous active-high reset
//   irq_src     level interrupt lines; a rising edge is an interrupt
//   mask_we     write strobe for the enable mask
//   mask_wdata  new enable mask value
//   ExtIAck     acknowledge from the processor (level)
//   ExtIRQ      interrupt request to the processor (registered)
//   irq_id      index of the requested source, valid while ExtIRQ=1
//   pending     pending register (observation)
//   mask        current enable mask
//   lost        sticky flags for edges that arrived on an already pending source
//
// Build option:
//   IRQ_SYNC_EN  when defined, each irq_src bit passes through a two-flop
//                synchronizer before edge detection (+2 cycles of latency).

module irq_controller #(
   parameter int NSRC = 8,
   parameter int IDW  = 3
) (
   input  logic            CLOCK_50,
   input  logic            reset,
   input  logic [NSRC-1:0] irq_src,
   input  logic            mask_we,
   input  logic [NSRC-1:0] mask_wdata,
   input  logic            ExtIAck,
   output logic            ExtIRQ,
   output logic [IDW-1:0]  irq_id,
   output logic [NSRC-1:0] pending,
   output logic [NSRC-1:0] mask,
   output logic [NSRC-1:0] lost
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT_REL} state_t;

   state_t          state;
   logic [NSRC-1:0] src;     // line value seen by the edge detector
   logic [NSRC-1:0] hist;    // previous sample of src
   logic [NSRC-1:0] rise;
   logic [NSRC-1:0] req;
   logic [NSRC-1:0] clr;
   logic [IDW-1:0]  winner;
   logic            any_req;

`ifdef IRQ_SYNC_EN
   logic [NSRC-1:0] sync_q1, sync_q2;

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         sync_q1 <= '0;
         sync_q2 <= '0;
      end else begin
         sync_q1 <= irq_src;
         sync_q2 <= sync_q1;
      end
   end

   assign src = sync_q2;
`else
   assign src = irq_src;
`endif

   assign rise    = src & ~hist;
   assign req     = pending & mask;
   assign any_req = |req;

   // Lowest index wins: scan from the top so the last hit is the lowest.
   always_comb begin
      winner = '0;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (req[i]) winner = IDW'(i);
      end
   end

   // Acknowledge only clears anything while a request is outstanding.
   always_comb begin
      clr = '0;
      if (state == REQ && ExtIAck) clr[irq_id] = 1'b1;
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         ExtIRQ  <= 1'b0;
         irq_id  <= '0;
         pending <= '0;
         lost    <= '0;
         mask    <= '1;
         hist    <= '0;
      end else begin
         hist <= src;
         if (mask_we) mask <= mask_wdata;

         // A new edge wins over the acknowledge clear of the same bit.
         pending <= (pending & ~clr) | rise;
         // An edge that coincides with the clear of its own bit is a fresh
         // event, not a coalesced one.
         lost    <= lost | (rise & pending & ~clr);

         case (state)
            IDLE: begin
               if (any_req) begin
                  state  <= REQ;
                  irq_id <= winner;
                  ExtIRQ <= 1'b1;
               end
            end
            REQ: begin
               // Committed: mask changes no longer withdraw the request.
               if (ExtIAck) begin
                  state  <= WAIT_REL;
                  ExtIRQ <= 1'b0;
               end
            end
            WAIT_REL: begin
               if (!ExtIAck) state <= IDLE;
            end
            default: begin
               state  <= IDLE;
               ExtIRQ <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller -- directed self-checking bench for irq_controller.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.

module tb_irq_controller;

`ifdef IRQ_SYNC_EN
   localparam int SYNC = 2;
`else
   localparam int SYNC = 0;
`endif

   logic       CLOCK_50;
   logic       reset;
   logic [7:0] irq_src;
   logic       mask_we;
   logic [7:0] mask_wdata;
   logic       ExtIAck;
   logic       ExtIRQ;
   logic [2:0] irq_id;
   logic [7:0] pending;
   logic [7:0] mask;
   logic [7:0] lost;

   int checks   = 0;
   int failures = 0;

   irq_controller #(.NSRC(8), .IDW(3)) dut (
      .CLOCK_50   (CLOCK_50),
      .reset      (reset),
      .irq_src    (irq_src),
      .mask_we    (mask_we),
      .mask_wdata (mask_wdata),
      .ExtIAck    (ExtIAck),
      .ExtIRQ     (ExtIRQ),
      .irq_id     (irq_id),
      .pending    (pending),
      .mask       (mask),
      .lost       (lost)
   );

   initial CLOCK_50 = 1'b0;
   always #5 CLOCK_50 = ~CLOCK_50;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge CLOCK_50);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset      = 1'b1;
      irq_src    = '0;
      mask_we    = 1'b0;
      mask_wdata = '0;
      ExtIAck    = 1'b0;
      #1;
      // Reset values while reset is held
      chk("rst_irq",   32'(ExtIRQ),  32'h0);
      chk("rst_id",    32'(irq_id),  32'h0);
      chk("rst_pend",  32'(pending), 32'h00);
      chk("rst_lost",  32'(lost),    32'h00);
      chk("rst_mask",  32'(mask),    32'hFF);
      tick(2);
      reset = 1'b0;
      tick(1);

      // Single pulse on source 3
      irq_src = 8'h08;
      tick(1 + SYNC);
      irq_src = 8'h00;
      chk("s3_pend",   32'(pending), 32'h08);
      chk("s3_noirq",  32'(ExtIRQ),  32'h0);
      tick(1);
      chk("s3_irq",    32'(ExtIRQ),  32'h1);
      chk("s3_id",     32'(irq_id),  32'h3);
      ExtIAck = 1'b1;
      tick(1);
      chk("s3_ackirq", 32'(ExtIRQ),  32'h0);
      chk("s3_clr",    32'(pending), 32'h00);
      ExtIAck = 1'b0;
      tick(2);
      chk("s3_idle",   32'(ExtIRQ),  32'h0);

      // Sources 5 and 2 in the same cycle: 2 first, then 5
      irq_src = 8'h24;
      tick(1 + SYNC);
      irq_src = 8'h00;
      chk("p_pend",    32'(pending), 32'h24);
      tick(1);
      chk("p_id2",     32'(irq_id),  32'h2);
      chk("p_irq2",    32'(ExtIRQ),  32'h1);
      ExtIAck = 1'b1;
      tick(1);
      chk("p_pend5",   32'(pending), 32'h20);
      ExtIAck = 1'b0;
      tick(1);
      chk("p_rel",     32'(ExtIRQ),  32'h0);
      tick(1);
      chk("p_irq5",    32'(ExtIRQ),  32'h1);
      chk("p_id5",     32'(irq_id),  32'h5);
      ExtIAck = 1'b1;
      tick(1);
      ExtIAck = 1'b0;
      chk("p_clr",     32'(pending), 32'h00);
      tick(1);

      // Two edges on source 1 before acknowledge
      irq_src = 8'h02;
      tick(1);
      irq_src = 8'h00;
      tick(1);
      irq_src = 8'h02;
      tick(1);
      irq_src = 8'h00;
      tick(SYNC);
      chk("l_lost",    32'(lost),    32'h02);
      chk("l_id",      32'(irq_id),  32'h1);
      chk("l_pend",    32'(pending), 32'h02);
      ExtIAck = 1'b1;
      tick(1);
      ExtIAck = 1'b0;
      chk("l_clr",     32'(pending), 32'h00);
      tick(3);
      chk("l_once",    32'(ExtIRQ),  32'h0);
      chk("l_sticky",  32'(lost),    32'h02);

      // Masked source 0 stays pending, not requested
      mask_we    = 1'b1;
      mask_wdata = 8'hFE;
      tick(1);
      mask_we    = 1'b0;
      chk("m_mask",    32'(mask),    32'hFE);
      irq_src = 8'h01;
      tick(1 + SYNC);
      irq_src = 8'h00;
      chk("m_pend",    32'(pending), 32'h01);
      tick(1);
      chk("m_noirq",   32'(ExtIRQ),  32'h0);
      // Acknowledge in IDLE is ignored
      ExtIAck = 1'b1;
      tick(1);
      ExtIAck = 1'b0;
      chk("m_ackidle", 32'(pending), 32'h01);
      mask_we    = 1'b1;
      mask_wdata = 8'hFF;
      tick(1);
      mask_we    = 1'b0;
      chk("m_wrirq",   32'(ExtIRQ),  32'h0);
      tick(1);
      chk("m_irq",     32'(ExtIRQ),  32'h1);
      chk("m_id",      32'(irq_id),  32'h0);
      // Masking the committed source keeps the request up
      mask_we    = 1'b1;
      mask_wdata = 8'hFE;
      tick(1);
      mask_we    = 1'b0;
      chk("m_commit",  32'(ExtIRQ),  32'h1);
      ExtIAck = 1'b1;
      tick(1);
      ExtIAck    = 1'b0;
      mask_we    = 1'b1;
      mask_wdata = 8'hFF;
      chk("m_clr",     32'(pending), 32'h00);
      tick(1);
      mask_we = 1'b0;
      tick(1);

      // New edge on source 4 on its own acknowledge edge
      irq_src = 8'h10;
      tick(1 + SYNC);
      irq_src = 8'h00;
      tick(1);
      chk("c_id",      32'(irq_id),  32'h4);
      irq_src = 8'h10;
      tick(SYNC);
      ExtIAck = 1'b1;
      tick(1);
      irq_src = 8'h00;
      chk("c_pend",    32'(pending), 32'h10);
      chk("c_lost",    32'(lost),    32'h02);
      chk("c_ackirq",  32'(ExtIRQ),  32'h0);
      ExtIAck = 1'b0;
      tick(2);
      chk("c_irq",     32'(ExtIRQ),  32'h1);
      chk("c_id2",     32'(irq_id),  32'h4);
      // Higher-priority source arrives: irq_id holds
      irq_src = 8'h01;
      tick(1 + SYNC);
      irq_src = 8'h00;
      chk("c_pend01",  32'(pending), 32'h11);
      chk("c_hold",    32'(irq_id),  32'h4);
      ExtIAck = 1'b1;
      tick(1);
      chk("c_holdw",   32'(irq_id),  32'h4);
      chk("c_left",    32'(pending), 32'h01);
      ExtIAck = 1'b0;
      tick(2);
      chk("c_id0",     32'(irq_id),  32'h0);
      ExtIAck = 1'b1;
      tick(1);
      ExtIAck = 1'b0;
      tick(1);

      // Reset mid-request
      irq_src = 8'h08;
      tick(1 + SYNC);
      irq_src = 8'h00;
      tick(1);
      chk("r_irq",     32'(ExtIRQ),  32'h1);
      #2;
      reset   = 1'b1;
      irq_src = 8'h04;   // held high through reset release
      #1;
      chk("r_drop",    32'(ExtIRQ),  32'h0);
      chk("r_pend",    32'(pending), 32'h00);
      chk("r_mask",    32'(mask),    32'hFF);
      chk("r_lost",    32'(lost),    32'h00);
      tick(1);
      reset = 1'b0;
      tick(1 + SYNC);
      chk("h_pend",    32'(pending), 32'h04);
      tick(1);
      chk("h_irq",     32'(ExtIRQ),  32'h1);
      chk("h_id",      32'(irq_id),  32'h2);
      irq_src = 8'h00;
      ExtIAck = 1'b1;
      tick(1);
      ExtIAck = 1'b0;
      tick(1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/irq_controller.md
IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 Parameter NSRC, default 8: number of interrupt sources, legal range 2..16.
REQ-002 Parameter IDW, default 3: width of irq_id; SHALL equal clog2(NSRC).
REQ-003 CLOCK_50  input  1  sole clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 irq_src  input  NSRC  level interrupt lines from peripherals; an interrupt is a rising edge on a line.
REQ-006 mask_we  input  1  write strobe for the enable mask.
REQ-007 mask_wdata  input  NSRC  new enable mask value.
REQ-008 ExtIAck  input  1  acknowledge from processor; a level input.
REQ-009 ExtIRQ  output  1  interrupt request to processor.
REQ-010 irq_id  output  IDW  index of the source being requested; valid while ExtIRQ=1.
REQ-011 pending  output  NSRC  pending register, for observation.
REQ-012 mask  output  NSRC  current enable mask.
REQ-013 lost  output  NSRC  sticky flags; lost[i] set on an edge of source i while pending[i]=1.

Function
REQ-014 Edge detect: pending[i] SHALL set on the clock edge where the sampled irq_src[i]=1 and the previous sample=0.
REQ-015 Pending SHALL be independent of mask; masked sources stay pending and are not requested.
REQ-016 Priority: among pending&mask, the lowest index wins.
REQ-017 FSM states: IDLE, REQ, WAIT_REL.
- IDLE->REQ when (pending&mask)!=0; latch winner into irq_id.
- REQ->WAIT_REL when ExtIAck=1; clear pending[irq_id] on that same edge.
- WAIT_REL->IDLE when ExtIAck=0.
REQ-018 ExtIRQ SHALL be 1 only in state REQ, and SHALL be driven from registered state with no combinational path from inputs.
REQ-019 irq_id SHALL hold stable throughout REQ and WAIT_REL, even if a higher-priority source becomes pending.
REQ-020 Latency without sync: edge sampled at edge k sets pending after k, and ExtIRQ=1 after edge k+1.
REQ-021 Committed request: clearing mask[irq_id] while in REQ SHALL NOT withdraw ExtIRQ.
REQ-022 Same-cycle set and clear of pending[irq_id] (new edge on the acknowledge edge): set wins and pending stays 1; lost is not set.
REQ-023 An edge on a source already pending coalesces: pending is unchanged and lost[i] is set.
REQ-024 lost[i] SHALL clear only on reset.
REQ-025 mask_we=1 SHALL update the mask on that edge; the new mask affects arbitration from the next cycle.
REQ-026 ExtIAck=1 seen in IDLE or WAIT_REL SHALL be ignored and SHALL NOT clear any pending bit.

Reset
REQ-027 Reset SHALL asynchronously force the following, with outputs valid during reset:
- state=IDLE, ExtIRQ=0, irq_id=0;
- pending=0, lost=0, mask=all ones;
- edge-detect history=0.
REQ-028 Reset asserted mid-request SHALL drop ExtIRQ immediately and lose all pending events.
REQ-029 A line held high through reset release SHALL raise pending on the first edge after release, because history resets to 0.

Configuration
REQ-030 Macro IRQ_SYNC_EN.
- Defined: each irq_src bit SHALL pass through a two-flop synchronizer (reset to 0) before edge detection, adding 2 cycles to REQ-020 latency.
- Undefined: irq_src is sampled directly, with the REQ-020 latency.

Verification
REQ-031 Single pulse on irq_src[3] -> ExtIRQ=1 two edges later with irq_id=3; ExtIAck 1 then 0 -> pending[3]=0, ExtIRQ=0, FSM in IDLE.
REQ-032 Edges on src 5 and 2 in the same cycle -> irq_id=2 first; after release, a second request with irq_id=5.
REQ-033 Two edges on src 1 before acknowledge -> lost[1]=1, exactly one request is served, and the lost flag stays set until reset.
REQ-034 mask=8'hFE with an edge on src 0 -> no ExtIRQ and pending[0]=1; mask write to 8'hFF -> ExtIRQ after the next edge with irq_id=0.
REQ-035 New edge on src 4 on the acknowledge edge of src 4 -> pending[4] stays 1 and a second request with irq_id=4 follows release.
REQ-036 Reset pulse during REQ -> ExtIRQ=0 asynchronously, pending=0, mask=8'hFF; rerun REQ-031 with IRQ_SYNC_EN defined -> request appears 2 cycles later.
